// File: rtl/rom_msg_sender.sv
// rom_msg_sender
//   Streams a fixed-length message out of a synchronous character ROM into a
//   UART-style valid/ready transmitter interface, one byte at a time.
//
//   Parameters
//     ROM_ADDR_WIDTH : ROM address width in bits
//     MSG_LEN        : message length in bytes, 1..2**ROM_ADDR_WIDTH
//
//   Ports
//     i_clk      : clock, rising edge
//     i_rstn     : asynchronous active-low reset
//     i_start    : request one message (sampled in IDLE only)
//     o_rom_addr : ROM read address (byte counter)
//     i_rom_dout : ROM data, valid one clock after the address
//     o_tx_data  : byte offered to the transmitter
//     o_tx_valid : o_tx_data is valid
//     i_tx_ready : transmitter accepts the byte
//     o_busy     : high in every state except IDLE
//     o_done     : one-cycle pulse at message end
//
//   Build option
//     MSG_SENDER_NUL_TERM_EN : when defined, a 8'h00 read from the ROM ends
//                              the message early and is not transmitted.

module rom_msg_sender #(
    parameter int unsigned ROM_ADDR_WIDTH = 5,
    parameter int unsigned MSG_LEN        = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start,
    output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [7:0]                i_rom_dout,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    // Counter is compared against the last address before incrementing, so a
    // full-depth message ends on the top address without wrapping.
    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_ADDR = ROM_ADDR_WIDTH'(MSG_LEN - 1);
    localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_ONE  = ROM_ADDR_WIDTH'(1);

    state_t                    state, state_nxt;
    logic [ROM_ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [7:0]                data_q, data_nxt;
    logic                      valid_q, valid_nxt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        valid_nxt = valid_q;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_FETCH;
                end
            end

            // Address has been stable for this cycle; ROM output appears in LOAD.
            ST_FETCH: state_nxt = ST_LOAD;

            ST_LOAD: begin
`ifdef MSG_SENDER_NUL_TERM_EN
                if (i_rom_dout == 8'h00) begin
                    state_nxt = ST_DONE;
                end else begin
                    data_nxt  = i_rom_dout;
                    valid_nxt = 1'b1;
                    state_nxt = ST_SEND;
                end
`else
                data_nxt  = i_rom_dout;
                valid_nxt = 1'b1;
                state_nxt = ST_SEND;
`endif
            end

            ST_SEND: begin
                if (i_tx_ready) begin
                    valid_nxt = 1'b0;
                    if (cnt == LAST_ADDR) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt   = cnt + ADDR_ONE;
                        state_nxt = ST_FETCH;
                    end
                end
            end

            ST_DONE: state_nxt = ST_IDLE;

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_rom_addr = cnt;
    assign o_tx_data  = data_q;
    assign o_tx_valid = valid_q;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);

endmodule

// File: tb/tb_rom_msg_sender.sv
// Scoreboard bench for rom_msg_sender: expected bytes are queued by the
// stimulus, a negedge monitor pops and compares every handshake.

module tb_rom_msg_sender;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [4:0] rom_addr;
    logic [7:0] rom_dout;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    logic       s_start;
    logic [0:0] s_rom_addr;
    logic [7:0] s_rom_dout;
    logic [7:0] s_tx_data;
    logic       s_tx_valid;
    logic       s_tx_ready;
    logic       s_busy;
    logic       s_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cnt   = 0;
    int s_done_cnt = 0;
    int last_hs    = -1;
    bit gap_en     = 0;
    logic prev_done   = 1'b0;
    logic s_prev_done = 1'b0;
    logic [7:0] q[$];
    logic [7:0] sq[$];

    rom_msg_sender dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (start),
        .o_rom_addr (rom_addr),
        .i_rom_dout (rom_dout),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    rom_msg_sender #(.ROM_ADDR_WIDTH(1), .MSG_LEN(1)) s_dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (s_start),
        .o_rom_addr (s_rom_addr),
        .i_rom_dout (s_rom_dout),
        .o_tx_data  (s_tx_data),
        .o_tx_valid (s_tx_valid),
        .i_tx_ready (s_tx_ready),
        .o_busy     (s_busy),
        .o_done     (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: 8'h41+addr, one clock latency
    always @(posedge clk) begin
`ifdef MSG_SENDER_NUL_TERM_EN
        rom_dout <= (rom_addr == 5'd4) ? 8'h00 : 8'h41 + {3'b000, rom_addr};
`else
        rom_dout <= 8'h41 + {3'b000, rom_addr};
`endif
        s_rom_dout <= 8'h41 + {7'b0, s_rom_addr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: handshake is valid&&ready sampled mid-cycle before the edge.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rstn) begin
            prev_done   = 1'b0;
            s_prev_done = 1'b0;
        end else begin
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_byte", {24'h0, tx_data}, 32'h100);
                end else begin
                    e = q.pop_front();
                    check("tx_byte", {24'h0, tx_data}, {24'h0, e});
                end
                if (gap_en) begin
                    if (last_hs >= 0) check("byte_period", cyc - last_hs, 3);
                    last_hs = cyc;
                end
            end
            if (done) begin
                check("done_width", prev_done, 0);
                done_cnt++;
            end
            prev_done = done;

            if (s_tx_valid && s_tx_ready) begin
                if (sq.size() == 0) begin
                    check("s_unexpected_byte", {24'h0, s_tx_data}, 32'h100);
                end else begin
                    e = sq.pop_front();
                    check("s_tx_byte", {24'h0, s_tx_data}, {24'h0, e});
                end
            end
            if (s_done) begin
                check("s_done_width", s_prev_done, 0);
                s_done_cnt++;
            end
            s_prev_done = s_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_msg(input int nbytes);
        for (int i = 0; i < nbytes; i++) q.push_back(8'(8'h41 + i));
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            tick();
            cycles++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic wait_offer(input logic [7:0] d, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!(tx_valid && tx_data == d) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("offer_seen", {31'h0, tx_valid && tx_data == d}, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  {27'h0, rom_addr}, 0);
        check({tag, "_data"},  {24'h0, tx_data}, 0);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rstn       = 1'b0;
        start      = 1'b0;
        tx_ready   = 1'b1;
        s_start    = 1'b0;
        s_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("s_rst_busy", s_busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

`ifndef MSG_SENDER_NUL_TERM_EN
        // Full message, ready always high: latency, order, byte period, done
        push_msg(32);
        done_cnt = 0;
        last_hs  = -1;
        gap_en   = 1;
        pulse_start();                      // now 1 ns after edge 1 (sampling edge)
        check("t1_busy_e1", busy, 1);
        check("t1_valid_e1", tx_valid, 0);
        check("t1_addr_e1", {27'h0, rom_addr}, 0);
        tick();
        check("t1_valid_e2", tx_valid, 0);
        tick();
        check("t1_valid_e3", tx_valid, 1);
        check("t1_data_e3", {24'h0, tx_data}, 32'h41);
        wait_done(200, n);
        check("t1_done_latency", n, 94);
        check("t1_valid_in_done", tx_valid, 0);
        tick();
        gap_en = 0;
        check("t1_busy_idle", busy, 0);
        check("t1_done_clear", done, 0);
        check("t1_q_empty", q.size(), 0);
        check("t1_done_cnt", done_cnt, 1);

        // Stall on byte 5 for 10 cycles
        push_msg(32);
        done_cnt = 0;
        pulse_start();
        wait_offer(8'h45, 40);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("t2_stall_valid", tx_valid, 1);
            check("t2_stall_data", {24'h0, tx_data}, 32'h46);
            check("t2_stall_addr", {27'h0, rom_addr}, 5);
            tick();
        end
        tx_ready = 1'b1;
        wait_offer(8'h47, 10);
        wait_done(200, n);
        tick();
        check("t2_q_empty", q.size(), 0);
        check("t2_done_cnt", done_cnt, 1);

        // Start held high: one message per IDLE entry
        push_msg(32);
        push_msg(32);
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        wait_done(200, n);
        tick();
        check("t3_idle_after_done", busy, 0);
        tick();
        check("t3_restart", busy, 1);
        check("t3_restart_addr", {27'h0, rom_addr}, 0);
        wait_done(200, n);
        start = 1'b0;
        tick();
        check("t3_busy_end", busy, 0);
        check("t3_q_empty", q.size(), 0);
        check("t3_done_cnt", done_cnt, 2);

        // Reset during SEND of byte 10
        push_msg(10);
        pulse_start();
        wait_offer(8'h4A, 60);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 10) begin
            tick();
            n++;
        end
        check("t4_byte10", {24'h0, tx_data}, 32'h4B);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t4_async");
        check("t4_q_empty", q.size(), 0);
        @(negedge clk);
        rstn     = 1'b1;
        tx_ready = 1'b1;
        push_msg(32);
        done_cnt = 0;
        pulse_start();
        check("t4_restart_addr", {27'h0, rom_addr}, 0);
        wait_done(200, n);
        tick();
        check("t4_q_empty_after", q.size(), 0);
        check("t4_done_cnt", done_cnt, 1);
`else
        // NUL at address 4 terminates the message after 4 bytes
        push_msg(4);
        done_cnt = 0;
        pulse_start();
        wait_done(60, n);
        check("nul_valid_in_done", tx_valid, 0);
        check("nul_addr_in_done", {27'h0, rom_addr}, 4);
        tick();
        check("nul_busy_idle", busy, 0);
        check("nul_q_empty", q.size(), 0);
        check("nul_done_cnt", done_cnt, 1);
`endif

        // Single-byte message on a 1-bit address
        sq.push_back(8'h41);
        s_done_cnt = 0;
        @(negedge clk);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("s_busy", s_busy, 1);
        tick();
        tick();
        check("s_valid_e3", s_tx_valid, 1);
        check("s_data_e3", {24'h0, s_tx_data}, 32'h41);
        tick();
        check("s_done", s_done, 1);
        check("s_addr_no_inc", {31'h0, s_rom_addr}, 0);
        check("s_valid_in_done", s_tx_valid, 0);
        tick();
        check("s_busy_idle", s_busy, 0);
        check("s_q_empty", sq.size(), 0);
        check("s_done_cnt", s_done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
